// File: rtl/mole_pkg.sv
// Shared definitions for the mole scheduler: state encoding, hole constants,
// LFSR feedback mask and the pick / SHOW-duration helper functions.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GAP  = 3'd1,
      SHOW = 3'd2,
      HIT  = 3'd3,
      OVER = 3'd4
   } state_e;

   localparam logic [2:0]  NO_MOLE   = 3'd7;
   localparam logic [2:0]  NUM_OVALS = 3'd5;
   // Galois feedback for taps 16/14/13/11 in right-shift form.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Folds the low LFSR bits onto a hole index and steps off the previous hole.
   function automatic logic [2:0] pick_hole(input logic [15:0] lfsr, input logic [2:0] last);
      logic [2:0] p;
      p = lfsr[2:0];
      if (p >= NUM_OVALS) p = p - NUM_OVALS;
      if (p == last) p = (p == NUM_OVALS - 3'd1) ? 3'd0 : p + 3'd1;
      return p;
   endfunction

   // SHOW length; with speedup it shrinks by step per point down to a floor.
   function automatic logic [31:0] show_duration(input logic [7:0]  score,
                                                 input logic [31:0] base,
                                                 input logic [31:0] step,
                                                 input logic [31:0] floor,
                                                 input logic        speedup);
      logic [31:0] dec;
      dec = 32'(score) * step;
      if (!speedup) return base;
      if (dec >= base || (base - dec) < floor) return floor;
      return base - dec;
   endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// 16-bit Galois LFSR that free-runs every cycle outside reset.
module lfsr16
   import mole_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   always_ff @(posedge clk) begin
      if (rst) state <= SEED;
      else     state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
   end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: picks holes, times SHOW/GAP/HIT, keeps score.
// Optional macro MOLE_SPEEDUP_EN shortens SHOW as the score grows.
//
// state | meaning
// IDLE  | waiting for start after reset
// GAP   | no mole shown, waiting GAP_CYCLES
// SHOW  | mole up at oval_select, waiting for a whack or timeout
// HIT   | struck mole held with mole_hit high
// OVER  | MAX_MISSES reached, score/misses frozen until start
module mole_scheduler
   import mole_pkg::*;
#(
   parameter int unsigned SHOW_CYCLES = 25000000,
   parameter int unsigned GAP_CYCLES  = 12500000,
   parameter int unsigned HIT_CYCLES  = 6250000,
   parameter int unsigned MAX_MISSES  = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int unsigned SPEED_STEP  = 1000000,
   parameter int unsigned SHOW_MIN    = 6250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       whack_valid,
   input  logic [2:0] whack_pos,
   output logic [2:0] oval_select,
   output logic       mole_hit,
   output logic [7:0] score,
   output logic [7:0] misses,
   output logic       game_over
);

   localparam logic [2:0]  S_IDLE   = IDLE;
   localparam logic [2:0]  S_GAP    = GAP;
   localparam logic [2:0]  S_SHOW   = SHOW;
   localparam logic [2:0]  S_HIT    = HIT;
   localparam logic [2:0]  S_OVER   = OVER;
   localparam logic [31:0] GAP_LOAD = GAP_CYCLES - 32'd1;
   localparam logic [31:0] HIT_LOAD = HIT_CYCLES - 32'd1;
   localparam logic [7:0]  MISS_END = 8'(MAX_MISSES);

   logic [2:0]  state;
   logic [31:0] timer;
   logic [2:0]  last_pos;
   logic [15:0] lfsr;
   logic [2:0]  pick;
   logic [31:0] show_len;
   logic [7:0]  miss_next;
   logic        timer_done;
   logic        good_whack;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

`ifdef MOLE_SPEEDUP_EN
   assign show_len = show_duration(score, SHOW_CYCLES, SPEED_STEP, SHOW_MIN, 1'b1);
`else
   assign show_len = show_duration(score, SHOW_CYCLES, SPEED_STEP, SHOW_MIN, 1'b0);
`endif

   assign pick       = pick_hole(lfsr, last_pos);
   assign timer_done = (timer == 32'd0);
   assign miss_next  = misses + 8'd1;
   assign good_whack = whack_valid && (whack_pos == oval_select);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         timer       <= 32'd0;
         oval_select <= NO_MOLE;
         mole_hit    <= 1'b0;
         score       <= 8'd0;
         misses      <= 8'd0;
         game_over   <= 1'b0;
         last_pos    <= NO_MOLE;
      end else begin
         if (!timer_done) timer <= timer - 32'd1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  score  <= 8'd0;
                  misses <= 8'd0;
                  timer  <= GAP_LOAD;
                  state  <= S_GAP;
               end
            end
            S_GAP: begin
               if (timer_done) begin
                  oval_select <= pick;
                  last_pos    <= pick;
                  timer       <= show_len - 32'd1;
                  state       <= S_SHOW;
               end
            end
            S_SHOW: begin
               // A hit on the expiry cycle takes priority over the miss.
               if (good_whack) begin
                  if (score != 8'hFF) score <= score + 8'd1;
                  mole_hit <= 1'b1;
                  timer    <= HIT_LOAD;
                  state    <= S_HIT;
               end else if (timer_done) begin
                  misses      <= miss_next;
                  oval_select <= NO_MOLE;
                  timer       <= GAP_LOAD;
                  if (miss_next == MISS_END) begin
                     game_over <= 1'b1;
                     state     <= S_OVER;
                  end else begin
                     state <= S_GAP;
                  end
               end
            end
            S_HIT: begin
               if (timer_done) begin
                  mole_hit    <= 1'b0;
                  oval_select <= NO_MOLE;
                  timer       <= GAP_LOAD;
                  state       <= S_GAP;
               end
            end
            S_OVER: begin
               if (start) begin
                  score     <= 8'd0;
                  misses    <= 8'd0;
                  game_over <= 1'b0;
                  timer     <= GAP_LOAD;
                  state     <= S_GAP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: cycle model of the game rules plus
// directed scenarios and randomized whacks.
module tb_mole_scheduler;

   localparam int SHOW = 8;
   localparam int GAP  = 4;
   localparam int HIT  = 2;
   localparam int MAXM = 3;
   localparam int STEP = 2;
   localparam int SMIN = 4;
`ifdef MOLE_SPEEDUP_EN
   localparam int LEN_S1 = 6;
   localparam int LEN_HI = 4;
`else
   localparam int LEN_S1 = 8;
   localparam int LEN_HI = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       whack_valid = 1'b0;
   logic [2:0] whack_pos = 3'd0;
   logic [2:0] oval_select;
   logic       mole_hit;
   logic [7:0] score;
   logic [7:0] misses;
   logic       game_over;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mole_scheduler #(
      .SHOW_CYCLES (SHOW),
      .GAP_CYCLES  (GAP),
      .HIT_CYCLES  (HIT),
      .MAX_MISSES  (MAXM),
      .LFSR_SEED   (16'hACE1),
      .SPEED_STEP  (STEP),
      .SHOW_MIN    (SMIN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .whack_valid (whack_valid),
      .whack_pos   (whack_pos),
      .oval_select (oval_select),
      .mole_hit    (mole_hit),
      .score       (score),
      .misses      (misses),
      .game_over   (game_over)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_GAP, M_SHOW, M_HIT, M_OVER} phase_t;
   phase_t      m_phase;
   int          m_left, m_score, m_miss, m_sel, m_last;
   bit          m_hit, m_over, m_rst_seen;
   logic [15:0] m_lfsr;

   function automatic int show_len(input int s);
`ifdef MOLE_SPEEDUP_EN
      int d;
      d = s * STEP;
      if (SHOW - d < SMIN) return SMIN;
      return SHOW - d;
`else
      return SHOW + 0 * s;
`endif
   endfunction

   always @(posedge clk) begin
      int p;
      m_rst_seen = rst;
      if (rst) begin
         m_phase = M_IDLE; m_left = 0; m_score = 0; m_miss = 0;
         m_sel = 7; m_last = 7; m_hit = 0; m_over = 0; m_lfsr = 16'hACE1;
      end else begin
         case (m_phase)
            M_IDLE, M_OVER: if (start) begin
               m_score = 0; m_miss = 0; m_over = 0;
               m_phase = M_GAP; m_left = GAP;
            end
            M_GAP: begin
               m_left--;
               if (m_left == 0) begin
                  p = int'(m_lfsr) % 8;
                  if (p >= 5) p -= 5;
                  if (p == m_last) p = (p + 1) % 5;
                  m_sel = p; m_last = p;
                  m_phase = M_SHOW; m_left = show_len(m_score);
               end
            end
            M_SHOW: begin
               if (whack_valid && int'(whack_pos) == m_sel) begin
                  if (m_score < 255) m_score++;
                  m_hit = 1; m_phase = M_HIT; m_left = HIT;
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_miss++; m_sel = 7;
                     if (m_miss == MAXM) begin m_phase = M_OVER; m_over = 1; end
                     else begin m_phase = M_GAP; m_left = GAP; end
                  end
               end
            end
            M_HIT: begin
               m_left--;
               if (m_left == 0) begin
                  m_hit = 0; m_sel = 7; m_phase = M_GAP; m_left = GAP;
               end
            end
            default: ;
         endcase
         m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
   end

   // ---------------- compare and run-length monitor ----------------
   int run_len = 0, seven_len = 0, last_run_len = 0, last_gap_len = 0, prev_mole = 7;

   always @(negedge clk) begin
      check("oval_select", oval_select, m_sel);
      check("mole_hit", mole_hit, m_hit);
      check("score", score, m_score);
      check("misses", misses, m_miss);
      check("game_over", game_over, m_over);
      check("oval_range", (oval_select <= 3'd4 || oval_select == 3'd7), 1);
      if (m_rst_seen) begin
         prev_mole = 7; run_len = 0; seven_len = 0;
      end else if (oval_select == 3'd7) begin
         if (run_len != 0) last_run_len = run_len;
         run_len = 0;
         seven_len++;
      end else begin
         if (run_len == 0) begin
            last_gap_len = seven_len;
            if (prev_mole != 7) check("no_repeat", int'(oval_select) != prev_mole, 1);
            prev_mole = int'(oval_select);
         end
         run_len++;
         seven_len = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic whack(input int pos);
      whack_valid = 1'b1; whack_pos = 3'(pos); tick();
      whack_valid = 1'b0; whack_pos = 3'd0;
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait budget expired at time %0t", name, $time);
   endtask

   task automatic wait_mole(input string name);
      int n = 0;
      while (oval_select != 3'd7 && n < 200) begin tick(); n++; end
      while (oval_select == 3'd7 && n < 200) begin tick(); n++; end
      if (n >= 200) timeout_fail(name);
   endtask

   task automatic wait_clear(input string name);
      int n = 0;
      while (oval_select != 3'd7 && n < 100) begin tick(); n++; end
      if (n >= 100) timeout_fail(name);
   endtask

   task automatic wait_over(input string name);
      int n = 0;
      while (!game_over && n < 500) begin tick(); n++; end
      if (n >= 500) timeout_fail(name);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int mb, sb, len, cnt, r;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(100);
      check("idle_oval", oval_select, 7);
      check("idle_score", score, 0);
      check("idle_misses", misses, 0);
      check("idle_over", game_over, 0);

      // Three unanswered moles end the game.
      pulse_start();
      wait_over("s2_over");
      check("s2_misses", misses, 3);
      check("s2_game_over", game_over, 1);
      check("s2_oval", oval_select, 7);
      check("s2_show_len", last_run_len, 8);
      check("s2_gap_len", last_gap_len, 4);

      // Hit in the third SHOW cycle, then play out to OVER and restart.
      pulse_start();
      wait_mole("s3_mole");
      tick(2);
      whack(m_sel);
      check("s3_hit1", mole_hit, 1);
      check("s3_score", score, 1);
      tick();
      check("s3_hit2", mole_hit, 1);
      tick();
      check("s3_hit_end", mole_hit, 0);
      check("s3_oval_clear", oval_select, 7);
      wait_over("s3_over");
      check("s3_frozen_score", score, 1);
      check("s3_show_len_s1", last_run_len, LEN_S1);
      pulse_start();
      check("s3_restart_score", score, 0);
      check("s3_restart_over", game_over, 0);

      // Wrong whacks are ignored and the mole still times out.
      wait_mole("s4_mole");
      mb = m_miss;
      tick();
      whack((m_sel + 1) % 5);
      whack(6);
      check("s4_no_hit", mole_hit, 0);
      wait_clear("s4_clear");
      check("s4_miss", misses, mb + 1);

      // Hit on the final SHOW cycle wins over the timeout.
      wait_mole("s5_mole");
      mb = m_miss;
      sb = m_score;
      len = show_len(m_score);
      tick(len - 1);
      whack(m_sel);
      check("s5_hit", mole_hit, 1);
      check("s5_misses", misses, mb);
      check("s5_score", score, sb + 1);

      // Reset in the middle of SHOW.
      wait_mole("s5b_mole");
      tick(2);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_oval", oval_select, 7);
      check("rst_hit", mole_hit, 0);
      check("rst_score", score, 0);
      check("rst_misses", misses, 0);
      check("rst_over", game_over, 0);

      // Randomized whacks over 50 rounds.
      pulse_start();
      for (int rd = 0; rd < 50; rd++) begin
         if (game_over) pulse_start();
         wait_mole("s6_mole");
         cnt = 0;
         while (m_phase == M_SHOW && cnt < 50) begin
            r = $urandom_range(0, 9);
            if (r < 2)      whack(m_sel);
            else if (r < 5) whack($urandom_range(0, 7));
            else            tick();
            cnt++;
         end
      end

      // Long play to saturate the score.
      rst = 1'b1; tick(); rst = 1'b0;
      pulse_start();
      for (int h = 0; h < 260; h++) begin
         wait_mole("s6_sat_mole");
         whack(m_sel);
      end
      check("s6_score_sat", score, 255);
      wait_mole("s6_last_mole");
      wait_clear("s6_last_clear");
      check("s6_show_len_hi", last_run_len, LEN_HI);
      check("s6_score_held", score, 255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
